// File: rtl/reorder_buffer_if.sv
// Decoder/CDB/commit-side signal bundle of the reorder buffer.
// The ROB is the slave end; the decoder/CDB/retire consumers form the master end.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4,
  parameter int DATA_W    = 32
);
  logic                 in_assign_ena;
  logic [DATA_W-1:0]    in_inst;
  logic [4:0]           in_reg_rd;
  logic [DATA_W-1:0]    in_pc;
  logic                 in_predicted_taken;
  logic [ROB_WIDTH-1:0] out_assigned_tag;
  logic                 out_full;
  logic [ROB_WIDTH-1:0] in_query_tag1;
  logic [ROB_WIDTH-1:0] in_query_tag2;
  logic                 out_query_tag1_ready;
  logic                 out_query_tag2_ready;
  logic [DATA_W-1:0]    out_query_ready_value1;
  logic [DATA_W-1:0]    out_query_ready_value2;
  logic                 in_cdb_ena;
  logic [ROB_WIDTH-1:0] in_cdb_tag;
  logic [DATA_W-1:0]    in_cdb_value;
  logic                 in_cdb_taken;
  logic [DATA_W-1:0]    in_cdb_target;
  logic                 out_commit_ena;
  logic [4:0]           out_commit_rd;
  logic [DATA_W-1:0]    out_commit_value;
  logic [ROB_WIDTH-1:0] out_commit_tag;
  logic                 out_store_commit_ena;
  logic [ROB_WIDTH-1:0] out_store_commit_tag;
  logic                 out_rollback;
  logic [DATA_W-1:0]    out_correct_pc;
  logic                 out_bp_update_ena;
  logic [DATA_W-1:0]    out_bp_pc;
  logic                 out_bp_taken;

  modport slave (
    input  in_assign_ena, in_inst, in_reg_rd, in_pc, in_predicted_taken,
    input  in_query_tag1, in_query_tag2,
    input  in_cdb_ena, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
    output out_assigned_tag, out_full,
    output out_query_tag1_ready, out_query_tag2_ready,
    output out_query_ready_value1, out_query_ready_value2,
    output out_commit_ena, out_commit_rd, out_commit_value, out_commit_tag,
    output out_store_commit_ena, out_store_commit_tag,
    output out_rollback, out_correct_pc,
    output out_bp_update_ena, out_bp_pc, out_bp_taken
  );

  modport master (
    output in_assign_ena, in_inst, in_reg_rd, in_pc, in_predicted_taken,
    output in_query_tag1, in_query_tag2,
    output in_cdb_ena, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
    input  out_assigned_tag, out_full,
    input  out_query_tag1_ready, out_query_tag2_ready,
    input  out_query_ready_value1, out_query_ready_value2,
    input  out_commit_ena, out_commit_rd, out_commit_value, out_commit_tag,
    input  out_store_commit_ena, out_store_commit_tag,
    input  out_rollback, out_correct_pc,
    input  out_bp_update_ena, out_bp_pc, out_bp_taken
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, operand queries, CDB capture,
// in-order retirement and flush on branch mispredict / JALR.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  typedef logic [ROB_WIDTH-1:0] tag_t;
  localparam tag_t CAP = tag_t'(DEPTH - 1);
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  tag_t             head_q, tail_q, count_q;
  logic [DEPTH-1:0] busy_q, ready_q;
  logic [DATA_W-1:0] inst_q   [DEPTH];
  logic [DATA_W-1:0] pc_q     [DEPTH];
  logic [DATA_W-1:0] value_q  [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];
  logic [4:0]        rd_q     [DEPTH];
  logic [DEPTH-1:0]  pred_q, taken_q;

  logic              commit_ena_p1, store_ena_p1, rollback_p1, bp_ena_p1, bp_taken_p1;
  logic [4:0]        commit_rd_p1;
  logic [DATA_W-1:0] commit_value_p1, correct_pc_p1, bp_pc_p1;
  tag_t              commit_tag_p1, store_tag_p1;

  function automatic tag_t next_tag(input tag_t t);
    return (t == CAP) ? tag_t'(1) : t + tag_t'(1);
  endfunction

  // An allocated entry is ready if it already holds a result or the CDB writes it right now.
  function automatic logic query_ready(input tag_t t);
    logic cdb_hit;
    cdb_hit = rob.in_cdb_ena && (rob.in_cdb_tag == t);
    return (t != '0) && busy_q[t] && (ready_q[t] || cdb_hit);
  endfunction

  function automatic logic [DATA_W-1:0] query_value(input tag_t t);
    if (!query_ready(t))                            return '0;
    else if (rob.in_cdb_ena && rob.in_cdb_tag == t) return rob.in_cdb_value;
    else                                            return value_q[t];
  endfunction

  logic [6:0] head_op;
  logic       commit_fire, alloc_fire, cdb_fire, mispredict, rollback_fire;

  always_comb begin
    head_op       = inst_q[head_q][6:0];
    commit_fire   = (count_q != '0) && ready_q[head_q];
    alloc_fire    = rob.in_assign_ena && (count_q != CAP);
    cdb_fire      = rob.in_cdb_ena && (rob.in_cdb_tag != '0) && busy_q[rob.in_cdb_tag];
    mispredict    = taken_q[head_q] != pred_q[head_q];
    rollback_fire = commit_fire &&
                    (((head_op == OP_BRANCH) && mispredict) || (head_op == OP_JALR));
  end

  assign rob.out_assigned_tag       = tail_q;
  assign rob.out_full               = count_q >= (CAP - tag_t'(1));
  assign rob.out_query_tag1_ready   = query_ready(rob.in_query_tag1);
  assign rob.out_query_tag2_ready   = query_ready(rob.in_query_tag2);
  assign rob.out_query_ready_value1 = query_value(rob.in_query_tag1);
  assign rob.out_query_ready_value2 = query_value(rob.in_query_tag2);

  // Entry payload: no reset, validity is tracked by busy_q/ready_q.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      inst_q[tail_q] <= rob.in_inst;
      rd_q[tail_q]   <= rob.in_reg_rd;
      pc_q[tail_q]   <= rob.in_pc;
      pred_q[tail_q] <= rob.in_predicted_taken;
    end
    if (cdb_fire) begin
      value_q[rob.in_cdb_tag]  <= rob.in_cdb_value;
      taken_q[rob.in_cdb_tag]  <= rob.in_cdb_taken;
      target_q[rob.in_cdb_tag] <= rob.in_cdb_target;
    end
  end

  // Pointer/status state and the registered commit-stage outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q          <= tag_t'(1);
      tail_q          <= tag_t'(1);
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      commit_ena_p1   <= 1'b0;
      commit_rd_p1    <= '0;
      commit_value_p1 <= '0;
      commit_tag_p1   <= '0;
      store_ena_p1    <= 1'b0;
      store_tag_p1    <= '0;
      rollback_p1     <= 1'b0;
      correct_pc_p1   <= '0;
      bp_ena_p1       <= 1'b0;
      bp_pc_p1        <= '0;
      bp_taken_p1     <= 1'b0;
    end else begin
      commit_ena_p1   <= commit_fire && (head_op != OP_STORE) && (head_op != OP_BRANCH) &&
                         (rd_q[head_q] != 5'd0);
      commit_rd_p1    <= commit_fire ? rd_q[head_q] : 5'd0;
      commit_value_p1 <= commit_fire ? value_q[head_q] : '0;
      commit_tag_p1   <= commit_fire ? head_q : '0;
      store_ena_p1    <= commit_fire && (head_op == OP_STORE);
      store_tag_p1    <= (commit_fire && (head_op == OP_STORE)) ? head_q : '0;
      bp_ena_p1       <= commit_fire && (head_op == OP_BRANCH);
      bp_pc_p1        <= (commit_fire && (head_op == OP_BRANCH)) ? pc_q[head_q] : '0;
      bp_taken_p1     <= commit_fire && (head_op == OP_BRANCH) && taken_q[head_q];
      rollback_p1     <= rollback_fire;
      if (!rollback_fire)       correct_pc_p1 <= '0;
      else if (head_op == OP_JALR || taken_q[head_q]) correct_pc_p1 <= target_q[head_q];
      else                      correct_pc_p1 <= pc_q[head_q] + DATA_W'(4);

      if (rollback_fire) begin
        head_q  <= tag_t'(1);
        tail_q  <= tag_t'(1);
        count_q <= '0;
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (cdb_fire) ready_q[rob.in_cdb_tag] <= 1'b1;
        if (commit_fire) begin
          head_q          <= next_tag(head_q);
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
        end
        if (alloc_fire) begin
          tail_q          <= next_tag(tail_q);
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
        count_q <= count_q + tag_t'(alloc_fire) - tag_t'(commit_fire);
      end
    end
  end

  assign rob.out_commit_ena       = commit_ena_p1;
  assign rob.out_commit_rd        = commit_rd_p1;
  assign rob.out_commit_value     = commit_value_p1;
  assign rob.out_commit_tag       = commit_tag_p1;
  assign rob.out_store_commit_ena = store_ena_p1;
  assign rob.out_store_commit_tag = store_tag_p1;
  assign rob.out_rollback         = rollback_p1;
  assign rob.out_correct_pc       = correct_pc_p1;
  assign rob.out_bp_update_ena    = bp_ena_p1;
  assign rob.out_bp_pc            = bp_pc_p1;
  assign rob.out_bp_taken         = bp_taken_p1;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  localparam logic [31:0] ADD_INST  = 32'h002082B3;
  localparam logic [31:0] BEQ_INST  = 32'h00000063;
  localparam logic [31:0] BNE_INST  = 32'h00001063;
  localparam logic [31:0] SW_INST   = 32'h00000023;
  localparam logic [31:0] JALR_INST = 32'h000080E7;

  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_WIDTH(4), .DATA_W(32)) rob ();

  reorder_buffer #(.ROB_WIDTH(4), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .rob(rob)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rob.in_assign_ena = 1'b0; rob.in_inst = '0; rob.in_reg_rd = '0; rob.in_pc = '0;
    rob.in_predicted_taken = 1'b0; rob.in_query_tag1 = '0; rob.in_query_tag2 = '0;
    rob.in_cdb_ena = 1'b0; rob.in_cdb_tag = '0; rob.in_cdb_value = '0;
    rob.in_cdb_taken = 1'b0; rob.in_cdb_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic alloc(input logic [31:0] inst, input logic [4:0] rd,
                       input logic [31:0] pc, input logic pred);
    rob.in_assign_ena = 1'b1; rob.in_inst = inst; rob.in_reg_rd = rd;
    rob.in_pc = pc; rob.in_predicted_taken = pred;
    tick();
    rob.in_assign_ena = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] value,
                     input logic taken, input logic [31:0] target);
    rob.in_cdb_ena = 1'b1; rob.in_cdb_tag = tag; rob.in_cdb_value = value;
    rob.in_cdb_taken = taken; rob.in_cdb_target = target;
    tick();
    rob.in_cdb_ena = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    total++; if (rob.out_assigned_tag !== 4'd1) $display("FAIL reset_tag: got %0d expected 1", rob.out_assigned_tag); else passed++;
    total++; if (rob.out_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", rob.out_full); else passed++;
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL reset_commit: got %b expected 0", rob.out_commit_ena); else passed++;
    total++; if (rob.out_rollback !== 1'b0) $display("FAIL reset_rollback: got %b expected 0", rob.out_rollback); else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_commit();
    do_reset();
    alloc(ADD_INST, 5'd5, 32'h0, 1'b0);
    total++; if (rob.out_assigned_tag !== 4'd2) $display("FAIL basic_tail: got %0d expected 2", rob.out_assigned_tag); else passed++;
    cdb(4'd1, 32'h2A, 1'b0, 32'h0);
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL basic_early: got %b expected 0", rob.out_commit_ena); else passed++;
    tick();
    total++; if (rob.out_commit_ena !== 1'b1) $display("FAIL basic_ena: got %b expected 1", rob.out_commit_ena); else passed++;
    total++; if (rob.out_commit_rd !== 5'd5) $display("FAIL basic_rd: got %0d expected 5", rob.out_commit_rd); else passed++;
    total++; if (rob.out_commit_value !== 32'h2A) $display("FAIL basic_value: got %h expected 0000002a", rob.out_commit_value); else passed++;
    total++; if (rob.out_commit_tag !== 4'd1) $display("FAIL basic_tag: got %0d expected 1", rob.out_commit_tag); else passed++;
    tick();
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL basic_pulse: got %b expected 0", rob.out_commit_ena); else passed++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 13; i++) alloc(ADD_INST, 5'd1, 32'h0, 1'b0);
    total++; if (rob.out_full !== 1'b0) $display("FAIL full_at13: got %b expected 0", rob.out_full); else passed++;
    alloc(ADD_INST, 5'd1, 32'h0, 1'b0);
    total++; if (rob.out_full !== 1'b1) $display("FAIL full_at14: got %b expected 1", rob.out_full); else passed++;
    total++; if (rob.out_assigned_tag !== 4'd15) $display("FAIL full_tag15: got %0d expected 15", rob.out_assigned_tag); else passed++;
    cdb(4'd1, 32'h1, 1'b0, 32'h0);
    tick();
    total++; if (rob.out_commit_tag !== 4'd1) $display("FAIL full_commit_tag: got %0d expected 1", rob.out_commit_tag); else passed++;
    total++; if (rob.out_full !== 1'b0) $display("FAIL full_release: got %b expected 0", rob.out_full); else passed++;
    alloc(ADD_INST, 5'd1, 32'h0, 1'b0);
    total++; if (rob.out_assigned_tag !== 4'd1) $display("FAIL wrap_tag: got %0d expected 1", rob.out_assigned_tag); else passed++;
    alloc(ADD_INST, 5'd1, 32'h0, 1'b0);
    total++; if (rob.out_assigned_tag !== 4'd2) $display("FAIL wrap_alloc1: got %0d expected 2", rob.out_assigned_tag); else passed++;
    alloc(ADD_INST, 5'd1, 32'h0, 1'b0);
    total++; if (rob.out_assigned_tag !== 4'd2) $display("FAIL full_ignore: got %0d expected 2", rob.out_assigned_tag); else passed++;
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(ADD_INST, 5'd2, 32'h0, 1'b0);
    rob.in_query_tag1 = 4'd3; rob.in_query_tag2 = 4'd0;
    rob.in_cdb_ena = 1'b1; rob.in_cdb_tag = 4'd3; rob.in_cdb_value = 32'h77;
    #1;
    total++; if (rob.out_query_tag1_ready !== 1'b1) $display("FAIL byp_ready: got %b expected 1", rob.out_query_tag1_ready); else passed++;
    total++; if (rob.out_query_ready_value1 !== 32'h77) $display("FAIL byp_value: got %h expected 00000077", rob.out_query_ready_value1); else passed++;
    total++; if (rob.out_query_tag2_ready !== 1'b0) $display("FAIL tag0_ready: got %b expected 0", rob.out_query_tag2_ready); else passed++;
    total++; if (rob.out_query_ready_value2 !== 32'h0) $display("FAIL tag0_value: got %h expected 0", rob.out_query_ready_value2); else passed++;
    tick();
    rob.in_cdb_ena = 1'b0; rob.in_query_tag2 = 4'd2;
    #1;
    total++; if (rob.out_query_ready_value1 !== 32'h77) $display("FAIL stored_value: got %h expected 00000077", rob.out_query_ready_value1); else passed++;
    total++; if (rob.out_query_tag2_ready !== 1'b0) $display("FAIL pending_ready: got %b expected 0", rob.out_query_tag2_ready); else passed++;
    clear_inputs();
  endtask

  task automatic test_branch_mispredict();
    do_reset();
    alloc(BEQ_INST, 5'd0, 32'h100, 1'b0);
    alloc(ADD_INST, 5'd7, 32'h104, 1'b0);
    cdb(4'd1, 32'h0, 1'b1, 32'h140);
    rob.in_assign_ena = 1'b1; rob.in_inst = ADD_INST; rob.in_reg_rd = 5'd8;
    tick();
    clear_inputs();
    total++; if (rob.out_rollback !== 1'b1) $display("FAIL mp_rollback: got %b expected 1", rob.out_rollback); else passed++;
    total++; if (rob.out_correct_pc !== 32'h140) $display("FAIL mp_pc: got %h expected 00000140", rob.out_correct_pc); else passed++;
    total++; if (rob.out_bp_update_ena !== 1'b1) $display("FAIL mp_bp_ena: got %b expected 1", rob.out_bp_update_ena); else passed++;
    total++; if (rob.out_bp_pc !== 32'h100) $display("FAIL mp_bp_pc: got %h expected 00000100", rob.out_bp_pc); else passed++;
    total++; if (rob.out_bp_taken !== 1'b1) $display("FAIL mp_bp_taken: got %b expected 1", rob.out_bp_taken); else passed++;
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL mp_no_write: got %b expected 0", rob.out_commit_ena); else passed++;
    total++; if (rob.out_assigned_tag !== 4'd1) $display("FAIL mp_tag: got %0d expected 1", rob.out_assigned_tag); else passed++;
    tick();
    total++; if (rob.out_rollback !== 1'b0) $display("FAIL mp_pulse: got %b expected 0", rob.out_rollback); else passed++;
    alloc(ADD_INST, 5'd9, 32'h140, 1'b0);
    cdb(4'd1, 32'h99, 1'b0, 32'h0);
    tick();
    total++; if (rob.out_commit_tag !== 4'd1) $display("FAIL mp_restart_tag: got %0d expected 1", rob.out_commit_tag); else passed++;
    total++; if (rob.out_commit_value !== 32'h99) $display("FAIL mp_restart_value: got %h expected 00000099", rob.out_commit_value); else passed++;
  endtask

  task automatic test_branch_ok_store();
    do_reset();
    alloc(BNE_INST, 5'd0, 32'h200, 1'b1);
    alloc(SW_INST, 5'd0, 32'h204, 1'b0);
    cdb(4'd1, 32'h0, 1'b1, 32'h300);
    cdb(4'd2, 32'h0, 1'b0, 32'h0);
    total++; if (rob.out_bp_update_ena !== 1'b1) $display("FAIL bne_bp_ena: got %b expected 1", rob.out_bp_update_ena); else passed++;
    total++; if (rob.out_bp_pc !== 32'h200) $display("FAIL bne_bp_pc: got %h expected 00000200", rob.out_bp_pc); else passed++;
    total++; if (rob.out_bp_taken !== 1'b1) $display("FAIL bne_bp_taken: got %b expected 1", rob.out_bp_taken); else passed++;
    total++; if (rob.out_rollback !== 1'b0) $display("FAIL bne_rollback: got %b expected 0", rob.out_rollback); else passed++;
    tick();
    total++; if (rob.out_store_commit_ena !== 1'b1) $display("FAIL sw_ena: got %b expected 1", rob.out_store_commit_ena); else passed++;
    total++; if (rob.out_store_commit_tag !== 4'd2) $display("FAIL sw_tag: got %0d expected 2", rob.out_store_commit_tag); else passed++;
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL sw_no_write: got %b expected 0", rob.out_commit_ena); else passed++;
    total++; if (rob.out_bp_update_ena !== 1'b0) $display("FAIL bp_pulse: got %b expected 0", rob.out_bp_update_ena); else passed++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(ADD_INST, 5'd3, 32'h0, 1'b0);
    alloc(ADD_INST, 5'd4, 32'h4, 1'b0);
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    tick();
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL ooo_wait1: got %b expected 0", rob.out_commit_ena); else passed++;
    tick();
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL ooo_wait2: got %b expected 0", rob.out_commit_ena); else passed++;
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    tick();
    total++; if (rob.out_commit_tag !== 4'd1) $display("FAIL ooo_tag1: got %0d expected 1", rob.out_commit_tag); else passed++;
    total++; if (rob.out_commit_value !== 32'h11) $display("FAIL ooo_value1: got %h expected 00000011", rob.out_commit_value); else passed++;
    total++; if (rob.out_commit_rd !== 5'd3) $display("FAIL ooo_rd1: got %0d expected 3", rob.out_commit_rd); else passed++;
    tick();
    total++; if (rob.out_commit_tag !== 4'd2) $display("FAIL ooo_tag2: got %0d expected 2", rob.out_commit_tag); else passed++;
    total++; if (rob.out_commit_value !== 32'h22) $display("FAIL ooo_value2: got %h expected 00000022", rob.out_commit_value); else passed++;
    total++; if (rob.out_commit_ena !== 1'b1) $display("FAIL ooo_ena2: got %b expected 1", rob.out_commit_ena); else passed++;
    tick();
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL ooo_done: got %b expected 0", rob.out_commit_ena); else passed++;
  endtask

  task automatic test_jalr_rd0_async();
    do_reset();
    alloc(JALR_INST, 5'd1, 32'h400, 1'b0);
    cdb(4'd1, 32'h404, 1'b0, 32'h800);
    tick();
    total++; if (rob.out_commit_ena !== 1'b1) $display("FAIL jalr_ena: got %b expected 1", rob.out_commit_ena); else passed++;
    total++; if (rob.out_commit_value !== 32'h404) $display("FAIL jalr_link: got %h expected 00000404", rob.out_commit_value); else passed++;
    total++; if (rob.out_rollback !== 1'b1) $display("FAIL jalr_rollback: got %b expected 1", rob.out_rollback); else passed++;
    total++; if (rob.out_correct_pc !== 32'h800) $display("FAIL jalr_pc: got %h expected 00000800", rob.out_correct_pc); else passed++;
    do_reset();
    alloc(32'h00000033, 5'd0, 32'h0, 1'b0);
    cdb(4'd1, 32'h5, 1'b0, 32'h0);
    tick();
    total++; if (rob.out_commit_ena !== 1'b0) $display("FAIL rd0_suppress: got %b expected 0", rob.out_commit_ena); else passed++;
    alloc(ADD_INST, 5'd6, 32'h0, 1'b0);
    alloc(ADD_INST, 5'd6, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (rob.out_assigned_tag !== 4'd1) $display("FAIL async_reset: got %0d expected 1", rob.out_assigned_tag); else passed++;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_query_bypass();
    test_branch_mispredict();
    test_branch_ok_store();
    test_out_of_order();
    test_jalr_rd0_async();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
